// File: rtl/free_running_stable_pkg.sv
// Shared types for the free-running timebase: the per-edge action chosen by the
// top level and the priority function that selects it.
package free_running_stable_pkg;

    typedef enum logic [1:0] {
        ACT_RECONFIG = 2'd0,
        ACT_WRAP     = 2'd1,
        ACT_COUNT    = 2'd2,
        ACT_HOLD     = 2'd3
    } action_e;

    // Reconfiguration beats everything, then a wrap, then a plain count step.
    function automatic action_e next_action(input logic mismatch,
                                            input logic en,
                                            input logic wrap);
        action_e act;
        if (mismatch) begin
            act = ACT_RECONFIG;
        end else if (wrap) begin
            act = ACT_WRAP;
        end else if (en) begin
            act = ACT_COUNT;
        end else begin
            act = ACT_HOLD;
        end
        return act;
    endfunction

endpackage

// File: rtl/free_running_stable_mod_counter.sv
// Modulo counter: counts enabled cycles from 0 to max, flags the terminal count
// so the wrap back to 0 happens without arithmetic overflow.
module free_running_stable_mod_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic [WIDTH-1:0] max,
    output logic             wrap
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    assign wrap = enable && (cnt_q == max);

    // Next count: clear wins, terminal count returns to 0, otherwise step or hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (wrap) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + WIDTH'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/free_running_stable.sv
// Programmable timebase: one-cycle tick every max_cnt+1 enabled cycles, with a
// stable flag that rises once a full period completes under an unchanged max_cnt.
module free_running_stable
    import free_running_stable_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] max_cnt,
    output logic             stable,
    output logic             tick
);

    logic [WIDTH-1:0] max_q;
    logic [WIDTH-1:0] max_d;
    logic             tick_q;
    logic             tick_d;
    logic             stable_q;
    logic             stable_d;
    logic             mismatch_s;
    logic             wrap_s;
    logic             clear_s;
    action_e          action_s;

    assign mismatch_s = (max_cnt != max_q);
    assign action_s   = next_action(mismatch_s, enable, wrap_s);

    free_running_stable_mod_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .clear  (clear_s),
        .max    (max_q),
        .wrap   (wrap_s)
    );

    // Next-state for the captured terminal count and the output flags.
    always_comb begin
        max_d    = max_q;
        tick_d   = 1'b0;
        stable_d = stable_q;
        clear_s  = 1'b0;
        case (action_s)
            ACT_RECONFIG: begin
                max_d    = max_cnt;
                stable_d = 1'b0;
                clear_s  = 1'b1;
            end
            ACT_WRAP: begin
                tick_d   = 1'b1;
                stable_d = 1'b1;
            end
            ACT_COUNT: begin
                tick_d   = 1'b0;
            end
            ACT_HOLD: begin
                tick_d   = 1'b0;
            end
            default: begin
                max_d    = max_q;
                tick_d   = 1'b0;
                stable_d = stable_q;
                clear_s  = 1'b0;
            end
        endcase
    end

    // Capture and output registers; reset overrides everything.
    always_ff @(posedge clk) begin
        if (!reset) begin
            max_q    <= '0;
            tick_q   <= 1'b0;
            stable_q <= 1'b0;
        end else begin
            max_q    <= max_d;
            tick_q   <= tick_d;
            stable_q <= stable_d;
        end
    end

    assign tick   = tick_q;
    assign stable = stable_q;

endmodule

// File: tb/tb_free_running_stable.sv
// Randomised and directed bench for free_running_stable against a model that
// tracks enabled cycles elapsed since the last capture.
module tb_free_running_stable;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             enable = 1'b0;
    logic [WIDTH-1:0] max_cnt = '0;
    logic             stable;
    logic             tick;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: captured terminal count, enabled edges since capture.
    int   max_m     = 0;
    int   elapsed_m = 0;
    logic tick_m    = 1'b0;
    logic stable_m  = 1'b0;

    free_running_stable #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .max_cnt (max_cnt),
        .stable  (stable),
        .tick    (tick)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    // Model: a tick whenever the enabled-edge count since capture hits a
    // multiple of the period; stable once at least one period has elapsed.
    task automatic model_edge(input logic r, input logic en, input int mx);
        if (!r) begin
            max_m = 0; elapsed_m = 0; tick_m = 1'b0; stable_m = 1'b0;
        end else if (mx != max_m) begin
            max_m = mx; elapsed_m = 0; tick_m = 1'b0; stable_m = 1'b0;
        end else if (en) begin
            elapsed_m++;
            tick_m   = ((elapsed_m % (max_m + 1)) == 0);
            stable_m = (elapsed_m >= (max_m + 1));
        end else begin
            tick_m = 1'b0;
        end
    endtask

    task automatic step(input logic r, input logic en, input int mx);
        @(negedge clk);
        reset   = r;
        enable  = en;
        max_cnt = WIDTH'(mx);
        @(posedge clk);
        model_edge(r, en, mx);
        #1;
        check_eq("tick", {31'd0, tick}, {31'd0, tick_m});
        check_eq("stable", {31'd0, stable}, {31'd0, stable_m});
    endtask

    initial begin
        int mx;
        logic en;
        logic r;

        // Reset hold
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 27);
        // Startup and several periods
        for (int i = 0; i < 120; i++) step(1'b1, 1'b1, 27);
        // Reconfigure
        for (int i = 0; i < 100; i++) step(1'b1, 1'b1, 28);
        // Enable gating mid-period
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 5);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 5);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 5);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 5);
        // Corner values
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 0);
        for (int i = 0; i < 600; i++) step(1'b1, 1'b1, 255);
        // Reset mid-period then startup again
        for (int i = 0; i < 14; i++) step(1'b1, 1'b1, 27);
        step(1'b0, 1'b1, 27);
        for (int i = 0; i < 70; i++) step(1'b1, 1'b1, 27);
        // max_cnt toggling every cycle
        for (int i = 0; i < 40; i++) step(1'b1, 1'b1, (i % 2 == 0) ? 3 : 4);
        // Reset release with max_cnt already 0
        step(1'b0, 1'b1, 0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 0);

        // Random traffic
        mx = 6;
        for (int i = 0; i < 3000; i++) begin
            en = ($urandom_range(0, 9) != 0);
            r  = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 49) == 0) begin
                mx = ($urandom_range(0, 19) == 0) ? 255 : int'($urandom_range(0, 12));
            end
            step(r, en, mx);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
